// File: rtl/peripheral_uart_rx_frontend_wb.sv
// peripheral_uart_rx_frontend_wb: synchronised, glitch-filtered rx line plus 16x baud enable generator
module peripheral_uart_rx_frontend_wb #(
  parameter int SYNC_STAGES = 2,
  parameter int DL_W = 16
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  input  logic [DL_W-1:0] dl,
  input  logic            dl_load,
  input  logic            srx_pad_i,
  input  logic            loopback,
  input  logic            stx_loop_i,
  output logic            srx_o,
  output logic            enable,
  output logic            rx_fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_sync;
  logic                   line;
  logic                   f0;
  logic                   f1;
  logic                   maj;
  logic [DL_W-1:0]        cnt;
  logic [DL_W-1:0]        cnt_n;
  logic                   en_n;
  logic [DL_W-1:0]        reload;
  assign s_sync = sync[SYNC_STAGES-1];
  // loopback source is already in the clk domain, so it bypasses the synchroniser
  assign line = loopback ? stx_loop_i : s_sync;
  assign maj = (f1 & f0) | (f1 & line) | (f0 & line);
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      sync    <= '1;
      f0      <= 1'b1;
      f1      <= 1'b1;
      srx_o   <= 1'b1;
      rx_fall <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], srx_pad_i};
      f0      <= line;
      f1      <= f0;
      srx_o   <= maj;
      rx_fall <= srx_o & ~maj;
    end
  end
  assign reload = dl - DL_W'(1);
  // a zero divisor parks the counter at 0 so a later nonzero dl ticks on the next edge
  always_comb begin
    cnt_n = dl_load ? reload : (dl == '0) ? '0 : (cnt == '0) ? reload : cnt - DL_W'(1);
    en_n  = !dl_load && (dl != '0) && (cnt == '0);
  end
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      cnt    <= '0;
      enable <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      enable <= en_n;
    end
  end
endmodule
